// File: rtl/sample_ramp_feeder.sv
// sample_ramp_feeder: buffers 16-bit offset-binary samples in a small FIFO and
// drives the delta-sigma modulator input u with a linear ramp toward each new
// sample. The ramp advances one step per modulator pulse.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   sample_in     16-bit sample written by the register bus
//   sample_we     one-cycle write strobe for sample_in
//   ramp_log2     L; each segment lasts 2^L pulses (sampled when a segment loads)
//   pulse_done    one-cycle modulator tick; the only event that advances the ramp
//   clear_flags   clears the sticky overflow/underrun flags
//   u_out         registered modulator input (sample in the top 16 bits)
//   fifo_level    FIFO occupancy, 0..depth
//   fifo_full     fifo_level == depth
//   overflow      sticky: a write arrived while the FIFO was full
//   underrun      sticky: a segment ended with no sample waiting
//   ramping       high while a segment is in progress
module sample_ramp_feeder #(
  parameter int unsigned IN_BITS        = 23,
  parameter int unsigned FIFO_LOG2      = 2,
  parameter int unsigned RAMP_LOG2_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               sample_in,
  input  logic                      sample_we,
  input  logic [RAMP_LOG2_BITS-1:0] ramp_log2,
  input  logic                      pulse_done,
  input  logic                      clear_flags,
  output logic [IN_BITS-1:0]        u_out,
  output logic [FIFO_LOG2:0]        fifo_level,
  output logic                      fifo_full,
  output logic                      overflow,
  output logic                      underrun,
  output logic                      ramping
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PAD_W    = IN_BITS - SAMPLE_W;
  localparam int unsigned DEPTH    = 1 << FIFO_LOG2;
  localparam int unsigned PTR_W    = FIFO_LOG2;
  localparam int unsigned LEVEL_W  = FIFO_LOG2 + 1;
  localparam int unsigned CNT_W    = (1 << RAMP_LOG2_BITS) + 1;
  localparam int unsigned DELTA_W  = IN_BITS + 1;

  localparam logic [LEVEL_W-1:0] DEPTH_LVL = LEVEL_W'(DEPTH);
  localparam logic [IN_BITS-1:0] MIDSCALE  = IN_BITS'(1) << (IN_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IN_BITS-1:0]         cur_q, cur_d;
  logic [IN_BITS-1:0]         target_q, target_d;
  logic signed [DELTA_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0]         level_q, level_d;
  logic                       full_q, full_d;
  logic                       overflow_q, overflow_d;
  logic                       underrun_q, underrun_d;
  logic                       ramping_q, ramping_d;
  logic [SAMPLE_W-1:0]        mem [DEPTH];

  logic                       fifo_empty;
  logic                       fifo_at_depth;
  logic                       push;
  logic                       pop;
  logic                       underrun_set;
  logic [SAMPLE_W-1:0]        head;
  logic [IN_BITS-1:0]         target_load;
  logic [IN_BITS-1:0]         base;
  logic signed [DELTA_W-1:0]  delta;
  logic signed [DELTA_W-1:0]  step_load;
  logic [CNT_W-1:0]           cnt_load;

  assign u_out      = cur_q;
  assign fifo_level = level_q;
  assign fifo_full  = full_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign ramping    = ramping_q;

  // Segment load values, computed from the FIFO head.
  always_comb begin
    fifo_empty    = (level_q == '0);
    fifo_at_depth = (level_q == DEPTH_LVL);
    push          = sample_we && !fifo_at_depth;
    head          = mem[rd_ptr_q];
    target_load   = {head, {PAD_W{1'b0}}};
    // Mid-ramp the new segment starts from where the old one ends, not from cur.
    base          = (state_q == RAMP) ? target_q : cur_q;
    delta         = $signed({1'b0, target_load}) - $signed({1'b0, base});
    step_load     = delta >>> ramp_log2;
    cnt_load      = CNT_W'(1) << ramp_log2;
  end

  // Next-state and datapath decode; nothing moves without pulse_done.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    target_d     = target_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    underrun_set = 1'b0;

    if (pulse_done) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (cnt_q > CNT_W'(1)) begin
            cur_d = IN_BITS'($signed({1'b0, cur_q}) + step_q);
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Final pulse lands exactly on target, discarding shift truncation.
            cur_d = target_q;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d      = HOLD;
              underrun_set = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = RAMP;
          end else begin
            underrun_set = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (pop) begin
      target_d = target_load;
      step_d   = step_load;
      cnt_d    = cnt_load;
    end
  end

  // FIFO pointers, level and sticky flags.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
    full_d   = (level_d == DEPTH_LVL);

    overflow_d = overflow_q;
    if (sample_we && fifo_at_depth) begin
      overflow_d = 1'b1;
    end else if (clear_flags) begin
      overflow_d = 1'b0;
    end

    underrun_d = underrun_q;
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (clear_flags) begin
      underrun_d = 1'b0;
    end

    ramping_d = (state_d == RAMP);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= MIDSCALE;
      target_q   <= MIDSCALE;
      step_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      ramping_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      target_q   <= target_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      ramping_q  <= ramping_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_q] <= sample_in;
    end
  end

endmodule

// File: tb/tb_sample_ramp_feeder.sv
// Testbench for sample_ramp_feeder: directed stimulus, a queue-based reference
// model checked every cycle, plus literal expectations at key points.
module tb_sample_ramp_feeder;

  localparam int IN_BITS = 23;
  localparam int DEPTH   = 4;
  localparam longint MID  = 64'h400000;
  localparam longint MASK = (64'd1 << IN_BITS) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [15:0]         sample_in;
  logic                sample_we;
  logic [3:0]          ramp_log2;
  logic                pulse_done;
  logic                clear_flags;
  logic [IN_BITS-1:0]  u_out;
  logic [2:0]          fifo_level;
  logic                fifo_full;
  logic                overflow;
  logic                underrun;
  logic                ramping;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  sample_ramp_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_we   (sample_we),
    .ramp_log2   (ramp_log2),
    .pulse_done  (pulse_done),
    .clear_flags (clear_flags),
    .u_out       (u_out),
    .fifo_level  (fifo_level),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .underrun    (underrun),
    .ramping     (ramping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 waiting for first sample, 1 ramping, 2 holding after a segment.
  logic [15:0] q[$];
  longint m_cur = MID, m_tgt = MID, m_base = MID, m_step = 0;
  int     m_k = 0, m_len = 1, m_mode = 0;
  bit     m_ovf = 0, m_und = 0;

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic m_load(input longint from);
    logic [15:0] s;
    s      = q.pop_front();
    m_tgt  = longint'(s) * 128;
    m_len  = 1 << ramp_log2;
    m_base = from;
    m_step = floor_div(m_tgt - from, longint'(m_len));
    m_k    = 0;
  endtask

  task automatic model_step();
    bit full_pre, push, ovf_set, und_set;
    if (reset) begin
      q.delete();
      m_cur = MID; m_tgt = MID; m_base = MID; m_step = 0;
      m_k = 0; m_len = 1; m_mode = 0; m_ovf = 0; m_und = 0;
      return;
    end
    full_pre = (q.size() == DEPTH);
    push     = sample_we && !full_pre;
    ovf_set  = sample_we && full_pre;
    und_set  = 0;
    if (pulse_done) begin
      if (m_mode == 1) begin
        m_k++;
        if (m_k < m_len) begin
          // Position after k pulses of a linear ramp from base.
          m_cur = (m_base + longint'(m_k) * m_step) & MASK;
        end else begin
          m_cur = m_tgt;
          if (q.size() > 0) m_load(m_tgt);
          else begin m_mode = 2; und_set = 1; end
        end
      end else if (q.size() > 0) begin
        m_load(m_cur);
        m_mode = 1;
      end else if (m_mode == 2) begin
        und_set = 1;
      end
    end
    if (push) q.push_back(sample_in);
    if (ovf_set) m_ovf = 1; else if (clear_flags) m_ovf = 0;
    if (und_set) m_und = 1; else if (clear_flags) m_und = 0;
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u_out",      longint'(u_out),      m_cur);
      chk("fifo_level", longint'(fifo_level), longint'(q.size()));
      chk("fifo_full",  longint'(fifo_full),  longint'(q.size() == DEPTH));
      chk("overflow",   longint'(overflow),   longint'(m_ovf));
      chk("underrun",   longint'(underrun),   longint'(m_und));
      chk("ramping",    longint'(ramping),    longint'(m_mode == 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit we, input logic [15:0] s, input bit pd, input bit clr);
    sample_we = we; sample_in = s; pulse_done = pd; clear_flags = clr;
    @(posedge clk); #1;
    sample_we = 0; pulse_done = 0; clear_flags = 0;
  endtask

  task automatic write(input logic [15:0] s);
    cyc(1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [IN_BITS-1:0] ramp_up_exp [4];

  initial begin
    reset = 1'b1; sample_in = '0; sample_we = 0; ramp_log2 = '0;
    pulse_done = 0; clear_flags = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // 1. idle after reset
    repeat (20) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("t1_u_out", longint'(u_out), 64'h400000);
    chk("t1_level", longint'(fifo_level), 0);
    chk("t1_ovf", longint'(overflow), 0);
    chk("t1_und", longint'(underrun), 0);
    chk("t1_ramping", longint'(ramping), 0);

    // 2. ramp up over 4 pulses
    ramp_log2 = 4'd2;
    write(16'h8400);
    chk("t2_level", longint'(fifo_level), 1);
    tick();
    chk("t2_load_u", longint'(u_out), 64'h400000);
    chk("t2_load_ramping", longint'(ramping), 1);
    ramp_up_exp[0] = 23'h408000; ramp_up_exp[1] = 23'h410000;
    ramp_up_exp[2] = 23'h418000; ramp_up_exp[3] = 23'h420000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_step%0d", i), longint'(u_out), longint'(ramp_up_exp[i]));
    end
    chk("t2_end_ramping", longint'(ramping), 0);
    chk("t2_end_und", longint'(underrun), 1);
    tick();
    chk("t2_hold_u", longint'(u_out), 64'h420000);
    chk("t2_hold_und", longint'(underrun), 1);
    chk("t2_hold_ramping", longint'(ramping), 0);

    // 3. truncation and exact snap (step = -1)
    do_reset();
    ramp_log2 = 4'd8;
    write(16'h7FFF);
    tick();
    for (int i = 0; i < 255; i++) tick();
    chk("t3_pre_snap", longint'(u_out), 64'h3FFF01);
    chk("t3_pre_ramping", longint'(ramping), 1);
    tick();
    chk("t3_snap", longint'(u_out), 64'h3FFF80);

    // 4. overflow, clear, pop order with L = 0
    do_reset();
    write(16'h1111); write(16'h2222); write(16'h3333); write(16'h4444); write(16'h5555);
    chk("t4_level", longint'(fifo_level), 4);
    chk("t4_full", longint'(fifo_full), 1);
    chk("t4_ovf", longint'(overflow), 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t4_ovf_clr", longint'(overflow), 0);
    ramp_log2 = 4'd0;
    tick();
    chk("t4_pop0_u", longint'(u_out), 64'h400000);
    chk("t4_pop0_level", longint'(fifo_level), 3);
    tick(); chk("t4_s1", longint'(u_out), 64'h088880);
    tick(); chk("t4_s2", longint'(u_out), 64'h111100);
    tick(); chk("t4_s3", longint'(u_out), 64'h199980);
    chk("t4_empty", longint'(fifo_level), 0);
    tick(); chk("t4_s4", longint'(u_out), 64'h222200);
    chk("t4_und", longint'(underrun), 1);
    tick(); chk("t4_no_fifth", longint'(u_out), 64'h222200);

    // 5a. write and pop in the same cycle at level 2
    do_reset();
    ramp_log2 = 4'd2;
    write(16'h9000); write(16'hA000);
    cyc(1'b1, 16'hB000, 1'b1, 1'b0);
    chk("t5_level_same", longint'(fifo_level), 2);
    chk("t5_ramping", longint'(ramping), 1);

    // 5b. underrun set beats clear_flags
    do_reset();
    ramp_log2 = 4'd0;
    write(16'h9000);
    tick(); tick();
    chk("t5_und_set", longint'(underrun), 1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    chk("t5_und_set_wins", longint'(underrun), 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t5_und_clr", longint'(underrun), 0);

    // 6a. L changed mid-segment takes effect at the next load
    do_reset();
    ramp_log2 = 4'd2;
    write(16'h8400); write(16'h8800);
    tick();
    tick(); chk("t6_a1", longint'(u_out), 64'h408000);
    ramp_log2 = 4'd0;
    tick(); chk("t6_a2", longint'(u_out), 64'h410000);
    tick(); chk("t6_a3", longint'(u_out), 64'h418000);
    tick(); chk("t6_a4", longint'(u_out), 64'h420000);
    chk("t6_a4_ramping", longint'(ramping), 1);
    tick(); chk("t6_b1", longint'(u_out), 64'h440000);
    chk("t6_b1_ramping", longint'(ramping), 0);

    // 6b. reset mid-ramp
    do_reset();
    ramp_log2 = 4'd2;
    write(16'h8400); write(16'h8800);
    tick(); tick();
    chk("t6_mid_u", longint'(u_out), 64'h408000);
    chk("t6_mid_level", longint'(fifo_level), 1);
    do_reset();
    chk("t6_rst_u", longint'(u_out), 64'h400000);
    chk("t6_rst_level", longint'(fifo_level), 0);
    chk("t6_rst_ramping", longint'(ramping), 0);

    repeat (3) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
